return_stack: RTL and testbench
===============================

# return_stack

Parametrised hardware return-address stack for the processor's call/return path. It holds up to DEPTH return addresses of DATA_W bits, with push, pop and a combined push+pop (replace-top for tail calls). It reports full/empty status, occupancy and a sticky error code. It sits between the control unit (Push/Pop strobes) and the PC-select mux (Ret_Add).

## Interface
- DATA_W, 13: width of a stored return address.
- DEPTH, 64: number of entries; power of two, minimum 2.
- CNT_W, $clog2(DEPTH)+1: width of Count (derived; do not override).

- Sys_Clock  input  1  system clock; all state changes on the falling edge.
- Reset  input  1  asynchronous, active-high reset.
- Push  input  1  push request; sampled on the falling edge.
- Pop  input  1  pop request; sampled on the falling edge.
- Push_Data  input  DATA_W  address to push (next-PC).
- Err_Clear  input  1  clears Err_Out/Err_Code; lower priority than a new error in the same cycle.
- Ret_Add  output  DATA_W  registered value of the last popped entry; holds until the next successful pop.
- Top_Data  output  DATA_W  current top entry, combinational from state; 0 when empty.
- Count  output  CNT_W  number of valid entries, 0..DEPTH.
- Empty  output  1  Count == 0.
- Full  output  1  Count == DEPTH.
- Err_Out  output  1  sticky error flag.
- Err_Code  output  2  sticky cause: 00 none, 01 overflow, 10 underflow; first error wins until cleared.

## Operation
- Reset values: Ret_Add=0, Count=0, Empty=1, Full=0, Err_Out=0, Err_Code=00, Top_Data=0, pointers=0. Memory contents are not reset.
- Each falling edge, one action applies:
  - Idle (Push=0, Pop=0): no change except Err_Clear.
  - Push only, not full: mem[top]=Push_Data, Count+1.
  - Push only, full: the entry is not written and Count is unchanged. Error set to overflow. With STACK_WRAP_EN the behaviour differs (see Configuration).
  - Pop only, not empty: Ret_Add=mem[top-1], Count-1.
  - Pop only, empty: Ret_Add unchanged. Error set to underflow.
  - Push+Pop, not empty: Ret_Add=old top, then the top slot is overwritten with Push_Data. Count is unchanged. This is legal when full, with no overflow.
  - Push+Pop, empty: behaves as a plain push (Count becomes 1). Underflow is set and Ret_Add is unchanged.
- Error register:
  - If Err_Out=0, any error loads Err_Code and sets Err_Out.
  - If Err_Out=1, Err_Code is held.
  - Err_Clear zeroes both, unless an error occurs in the same edge. In that case the new error is loaded.
- Pointer arithmetic uses $clog2(DEPTH) bits and wraps modulo DEPTH. Count is one bit wider so it can represent DEPTH.

## Timing
- Latency is one falling edge from request to updated Count, Full, Empty, Top_Data and Ret_Add.
- Top_Data is valid in the same half-cycle as the Count update. There is no read latency (asynchronous-read memory).
- Back-to-back pushes or pops are allowed every cycle. There is no handshake or stall; requests are never queued.
- Reset asserted mid-operation clears state immediately, without a clock. Release is synchronised by the consumer.

## Configuration
- STACK_WRAP_EN defined: the stack is circular.
  - A push when full overwrites the oldest entry: the base pointer advances and Count stays at DEPTH.
  - No overflow error is raised.
  - Underflow behaviour is unchanged.
- STACK_WRAP_EN undefined: there is no base pointer (bottom is fixed at 0). A push when full is dropped with overflow, as in Operation.

## Structure
- Package stack_pkg holds:
  - the Err_Code localparams ERR_NONE, ERR_OVF and ERR_UDF;
  - a function for the pointer width.
- Sub-module stack_mem: DEPTH x DATA_W register array with a falling-edge write port and an asynchronous read port. It has no reset. return_stack holds all control, pointers and error logic.

## Test plan
- Reset, then push 0x0010, 0x0020, 0x0030 -> Count=3, Top_Data=0x0030. Pop, pop -> Ret_Add=0x0030 then 0x0020, Count=1.
- Pop while empty -> Err_Out=1, Err_Code=10, Ret_Add unchanged. Assert Err_Clear -> Err_Out=0, Err_Code=00.
- Fill with DEPTH pushes (values 1..DEPTH) -> Full=1. One more push of 0x1FFF:
  - without STACK_WRAP_EN -> Err_Code=01, Top_Data=DEPTH;
  - with STACK_WRAP_EN -> no error, Top_Data=0x1FFF, DEPTH pops return 0x1FFF, DEPTH..2.
- With Count=2 and top 0x0040, assert Push+Pop with 0x0055 -> Ret_Add=0x0040, Top_Data=0x0055, Count=2.
- Overflow error pending, then underflow -> Err_Code stays 01. Err_Clear together with a new underflow -> Err_Code=10.
- Assert Reset between clock edges with Count=5 -> Count=0, Empty=1, Ret_Add=0, Err_Out=0 immediately.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared constants and helpers for the return-address stack.
// Error-cause encodings and the pointer-width helper used by return_stack.
package stack_pkg;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_OVF  = 2'b01;
   localparam logic [1:0] ERR_UDF  = 2'b10;

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/stack_mem.sv
// Stack storage: DEPTH x DATA_W register array, falling-edge write,
// asynchronous read. Contents are deliberately not reset.
module stack_mem #(
   parameter int DATA_W = 13,
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 6
) (
   input  logic              Sys_Clock,
   input  logic              We,
   input  logic [ADDR_W-1:0] Wr_Addr,
   input  logic [DATA_W-1:0] Wr_Data,
   input  logic [ADDR_W-1:0] Rd_Addr,
   output logic [DATA_W-1:0] Rd_Data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(negedge Sys_Clock) begin
      if (We) mem[Wr_Addr] <= Wr_Data;
   end

   assign Rd_Data = mem[Rd_Addr];

endmodule

// File: rtl/return_stack.sv
// Return-address stack with push, pop, replace-top and sticky error reporting.
// Define STACK_WRAP_EN for a circular stack that overwrites the oldest entry when full.
module return_stack
   import stack_pkg::*;
#(
   parameter int DATA_W = 13,
   parameter int DEPTH  = 64,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic              Sys_Clock,
   input  logic              Reset,
   input  logic              Push,
   input  logic              Pop,
   input  logic [DATA_W-1:0] Push_Data,
   input  logic              Err_Clear,
   output logic [DATA_W-1:0] Ret_Add,
   output logic [DATA_W-1:0] Top_Data,
   output logic [CNT_W-1:0]  Count,
   output logic              Empty,
   output logic              Full,
   output logic              Err_Out,
   output logic [1:0]        Err_Code
);

   localparam int               PTR_W    = ptr_width(DEPTH);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   logic [CNT_W-1:0]  count;
   logic [PTR_W-1:0]  top_ptr;
   logic [PTR_W-1:0]  top_m1;
   logic              empty;
   logic              full;
   logic              we;
   logic [PTR_W-1:0]  waddr;
   logic [DATA_W-1:0] rd_data;
   logic              cnt_inc;
   logic              cnt_dec;
   logic              ret_ld;
   logic              err_set;
   logic [1:0]        err_val;
   logic [DATA_W-1:0] ret_add;
   logic              err_out;
   logic [1:0]        err_code;

`ifdef STACK_WRAP_EN
   logic [PTR_W-1:0] base;
   logic             base_inc;

   always_ff @(negedge Sys_Clock or posedge Reset) begin
      if (Reset)         base <= '0;
      else if (base_inc) base <= base + PTR_ONE;
   end

   // When full the low count bits are zero, so top_ptr lands on the oldest slot.
   assign top_ptr = base + count[PTR_W-1:0];
`else
   assign top_ptr = count[PTR_W-1:0];
`endif

   assign top_m1 = top_ptr - PTR_ONE;
   assign empty  = (count == '0);
   assign full   = (count == CNT_FULL);

   always_comb begin
      we      = 1'b0;
      waddr   = top_ptr;
      cnt_inc = 1'b0;
      cnt_dec = 1'b0;
      ret_ld  = 1'b0;
      err_set = 1'b0;
      err_val = ERR_NONE;
`ifdef STACK_WRAP_EN
      base_inc = 1'b0;
`endif
      case ({Push, Pop})
         2'b10: begin
            if (!full) begin
               we      = 1'b1;
               cnt_inc = 1'b1;
            end else begin
`ifdef STACK_WRAP_EN
               we       = 1'b1;
               base_inc = 1'b1;
`else
               err_set = 1'b1;
               err_val = ERR_OVF;
`endif
            end
         end
         2'b01: begin
            if (!empty) begin
               ret_ld  = 1'b1;
               cnt_dec = 1'b1;
            end else begin
               err_set = 1'b1;
               err_val = ERR_UDF;
            end
         end
         2'b11: begin
            // Tail call: hand back the old top and overwrite it in place.
            if (!empty) begin
               ret_ld = 1'b1;
               we     = 1'b1;
               waddr  = top_m1;
            end else begin
               we      = 1'b1;
               cnt_inc = 1'b1;
               err_set = 1'b1;
               err_val = ERR_UDF;
            end
         end
         default: ;
      endcase
   end

   always_ff @(negedge Sys_Clock or posedge Reset) begin
      if (Reset) begin
         count    <= '0;
         ret_add  <= '0;
         err_out  <= 1'b0;
         err_code <= ERR_NONE;
      end else begin
         if (cnt_inc)      count <= count + CNT_ONE;
         else if (cnt_dec) count <= count - CNT_ONE;
         if (ret_ld) ret_add <= rd_data;
         // First error sticks; a clear only yields to an error on the same edge.
         if (err_set && (!err_out || Err_Clear)) begin
            err_out  <= 1'b1;
            err_code <= err_val;
         end else if (Err_Clear) begin
            err_out  <= 1'b0;
            err_code <= ERR_NONE;
         end
      end
   end

   stack_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (PTR_W)
   ) u_mem (
      .Sys_Clock (Sys_Clock),
      .We        (we),
      .Wr_Addr   (waddr),
      .Wr_Data   (Push_Data),
      .Rd_Addr   (top_m1),
      .Rd_Data   (rd_data)
   );

   assign Ret_Add  = ret_add;
   assign Top_Data = empty ? '0 : rd_data;
   assign Count    = count;
   assign Empty    = empty;
   assign Full     = full;
   assign Err_Out  = err_out;
   assign Err_Code = err_code;

endmodule

// File: tb/tb_return_stack.sv
// Bench for return_stack: queue-based reference stack plus a scoreboard of expected
// Ret_Add values; STACK_WRAP_EN selects the circular-stack expectations.
module tb_return_stack;

   localparam int DATA_W = 13;
   localparam int DEPTH  = 64;
   localparam int CNT_W  = $clog2(DEPTH) + 1;

   logic              Sys_Clock = 1'b0;
   logic              Reset     = 1'b1;
   logic              Push      = 1'b0;
   logic              Pop       = 1'b0;
   logic [DATA_W-1:0] Push_Data = '0;
   logic              Err_Clear = 1'b0;
   logic [DATA_W-1:0] Ret_Add;
   logic [DATA_W-1:0] Top_Data;
   logic [CNT_W-1:0]  Count;
   logic              Empty;
   logic              Full;
   logic              Err_Out;
   logic [1:0]        Err_Code;

   int checks   = 0;
   int failures = 0;

   logic [DATA_W-1:0] model_q [$];
   logic [DATA_W-1:0] exp_q   [$];
   logic [DATA_W-1:0] m_ret  = '0;
   logic              m_err  = 1'b0;
   logic [1:0]        m_code = 2'b00;

   return_stack #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) dut (
      .Sys_Clock (Sys_Clock),
      .Reset     (Reset),
      .Push      (Push),
      .Pop       (Pop),
      .Push_Data (Push_Data),
      .Err_Clear (Err_Clear),
      .Ret_Add   (Ret_Add),
      .Top_Data  (Top_Data),
      .Count     (Count),
      .Empty     (Empty),
      .Full      (Full),
      .Err_Out   (Err_Out),
      .Err_Code  (Err_Code)
   );

   always #5 Sys_Clock = ~Sys_Clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_apply(input logic p, input logic q, input logic [DATA_W-1:0] d, input logic c);
      logic       e    = 1'b0;
      logic [1:0] code = 2'b00;
      int         n    = model_q.size();
      if (p && !q) begin
         if (n < DEPTH) model_q.push_back(d);
         else begin
`ifdef STACK_WRAP_EN
            void'(model_q.pop_front());
            model_q.push_back(d);
`else
            e = 1'b1; code = 2'b01;
`endif
         end
      end else if (!p && q) begin
         if (n > 0) begin
            m_ret = model_q.pop_back();
            exp_q.push_back(m_ret);
         end else begin
            e = 1'b1; code = 2'b10;
         end
      end else if (p && q) begin
         if (n > 0) begin
            m_ret = model_q[n-1];
            exp_q.push_back(m_ret);
            model_q[n-1] = d;
         end else begin
            model_q.push_back(d);
            e = 1'b1; code = 2'b10;
         end
      end
      if (e && (!m_err || c)) begin
         m_err = 1'b1; m_code = code;
      end else if (c) begin
         m_err = 1'b0; m_code = 2'b00;
      end
   endtask

   task automatic compare_all(input string tag);
      logic [DATA_W-1:0] exp_ret;
      logic [DATA_W-1:0] exp_top;
      exp_ret = (exp_q.size() > 0) ? exp_q.pop_front() : m_ret;
      exp_top = (model_q.size() > 0) ? model_q[model_q.size()-1] : '0;
      check({tag, ".count"}, 32'(Count), 32'(model_q.size()));
      check({tag, ".empty"}, 32'(Empty), 32'(model_q.size() == 0));
      check({tag, ".full"},  32'(Full),  32'(model_q.size() == DEPTH));
      check({tag, ".top"},   32'(Top_Data), 32'(exp_top));
      check({tag, ".ret"},   32'(Ret_Add),  32'(exp_ret));
      check({tag, ".err"},   32'(Err_Out),  32'(m_err));
      check({tag, ".code"},  32'(Err_Code), 32'(m_code));
   endtask

   task automatic step(input logic p, input logic q, input logic [DATA_W-1:0] d,
                       input logic c, input string tag);
      @(posedge Sys_Clock);
      Push = p; Pop = q; Push_Data = d; Err_Clear = c;
      model_apply(p, q, d, c);
      @(negedge Sys_Clock);
      #1;
      Push = 1'b0; Pop = 1'b0; Err_Clear = 1'b0;
      compare_all(tag);
   endtask

   initial begin
      #2;
      check("rst.count", 32'(Count), 0);
      check("rst.empty", 32'(Empty), 1);
      check("rst.full",  32'(Full), 0);
      check("rst.ret",   32'(Ret_Add), 0);
      check("rst.top",   32'(Top_Data), 0);
      check("rst.err",   32'(Err_Out), 0);
      check("rst.code",  32'(Err_Code), 0);
      @(posedge Sys_Clock);
      Reset = 1'b0;

      step(1, 0, 13'h0010, 0, "push10");
      step(1, 0, 13'h0020, 0, "push20");
      step(1, 0, 13'h0030, 0, "push30");
      check("tp1.count3", 32'(Count), 3);
      check("tp1.top30", 32'(Top_Data), 32'h30);
      step(0, 1, '0, 0, "pop30");
      check("tp1.ret30", 32'(Ret_Add), 32'h30);
      step(0, 1, '0, 0, "pop20");
      check("tp1.ret20", 32'(Ret_Add), 32'h20);
      check("tp1.count1", 32'(Count), 1);
      step(0, 1, '0, 0, "pop10");

      step(0, 1, '0, 0, "udf");
      check("udf.code", 32'(Err_Code), 2);
      check("udf.ret_hold", 32'(Ret_Add), 32'h10);
      step(0, 0, '0, 1, "clr");
      check("clr.err", 32'(Err_Out), 0);

      for (int i = 1; i <= DEPTH; i++) step(1, 0, DATA_W'(i), 0, "fill");
      check("fill.full", 32'(Full), 1);
      step(1, 0, 13'h1FFF, 0, "push_full");
`ifdef STACK_WRAP_EN
      check("wrap.err", 32'(Err_Out), 0);
      check("wrap.top", 32'(Top_Data), 32'h1FFF);
`else
      check("ovf.code", 32'(Err_Code), 1);
      check("ovf.top", 32'(Top_Data), DEPTH);
`endif
      while (model_q.size() > 0) step(0, 1, '0, 0, "drain");
      step(0, 1, '0, 0, "udf_after");
`ifndef STACK_WRAP_EN
      check("sticky.ovf", 32'(Err_Code), 1);
`endif
      step(0, 1, '0, 1, "clr_udf");
      check("clr_udf.code", 32'(Err_Code), 2);
      step(0, 0, '0, 1, "clr2");

      step(1, 0, 13'h0011, 0, "push11");
      step(1, 0, 13'h0040, 0, "push40");
      step(1, 1, 13'h0055, 0, "pushpop");
      check("pp.ret", 32'(Ret_Add), 32'h40);
      check("pp.top", 32'(Top_Data), 32'h55);
      check("pp.count", 32'(Count), 2);
      step(0, 1, '0, 0, "pop55");
      step(0, 1, '0, 0, "pop11");
      step(1, 1, 13'h0077, 0, "pushpop_empty");
      check("ppe.count", 32'(Count), 1);
      check("ppe.code", 32'(Err_Code), 2);
      check("ppe.ret", 32'(Ret_Add), 32'h11);
      step(0, 0, '0, 1, "clr3");

      for (int i = 0; i < 80; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              DATA_W'($urandom), 1'($urandom_range(0, 7) == 0), "rnd");

      while (model_q.size() > 0) step(0, 1, '0, 0, "drain2");
      step(0, 0, '0, 1, "clr4");
      for (int i = 1; i <= DEPTH; i++) step(1, 0, DATA_W'(i + 100), 0, "fill2");
      step(1, 1, 13'h0ABC, 0, "pushpop_full");
      check("ppf.full", 32'(Full), 1);
      check("ppf.err", 32'(Err_Out), 0);
      check("ppf.top", 32'(Top_Data), 32'hABC);
      while (model_q.size() > 5) step(0, 1, '0, 0, "down5");
      check("pre_rst.count", 32'(Count), 5);

      @(posedge Sys_Clock);
      #2;
      Reset = 1'b1;
      #1;
      check("async_rst.count", 32'(Count), 0);
      check("async_rst.empty", 32'(Empty), 1);
      check("async_rst.ret", 32'(Ret_Add), 0);
      check("async_rst.err", 32'(Err_Out), 0);
      check("async_rst.top", 32'(Top_Data), 0);
      model_q.delete();
      exp_q.delete();
      m_ret = '0; m_err = 1'b0; m_code = 2'b00;
      #1;
      Reset = 1'b0;
      step(1, 0, 13'h0123, 0, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
